// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder and tone register bank.
// Covers FSM state encoding, command byte fields and the tone register map.
package spi_cmd_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int CMD_AUTO_INC_BIT = 7;

    // Register-map indices consumed by the tone channels
    localparam int REG_TONE_A_LO = 0;
    localparam int REG_TONE_A_HI = 1;
    localparam int REG_TONE_B_LO = 2;
    localparam int REG_TONE_B_HI = 3;
    localparam int REG_TONE_C_LO = 4;
    localparam int REG_TONE_C_HI = 5;
    localparam int REG_NOISE     = 6;
    localparam int REG_MIXER     = 7;
    localparam int REG_VOL_A     = 8;
    localparam int REG_VOL_B     = 9;
    localparam int REG_VOL_C     = 10;

endpackage

// File: rtl/spi_reg_bank.sv
// Tone register bank: single write port, flat read bus.
// With SHADOW_COMMIT_EN defined, writes land in a shadow bank committed when the transaction ends.
module spi_reg_bank
    import spi_cmd_decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  wr_en,
    input  logic [ADDR_WIDTH-1:0]                 wr_addr,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic                                  txn_active,
    output logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0] regs
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] active_q [NUM_REGS];

`ifdef SHADOW_COMMIT_EN
    logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
    logic                  dirty;

    // Commit only after at least one write, so empty transactions leave active untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= '0;
                shadow_q[i] <= '0;
            end
            dirty <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow_q[wr_addr] <= wr_data;
                dirty             <= 1'b1;
            end
            if (!txn_active && dirty) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                dirty <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= '0;
            end
        end else if (wr_en) begin
            active_q[wr_addr] <= wr_data;
        end
    end
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI transactions (command byte + data bytes) into tone register writes.
// Optional SHADOW_COMMIT_EN makes multi-register updates atomic per transaction.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic [7:0]                            rx_data_in,
    input  logic                                  rx_valid_in,
    input  logic                                  transaction_valid_in,
    output logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0] regs_out,
    output logic                                  wr_strobe_out,
    output logic [ADDR_WIDTH-1:0]                 wr_addr_out,
    output logic                                  cmd_error_out,
    output logic [1:0]                            state_out
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_ptr, addr_nxt;
    logic                  auto_inc, auto_nxt;
    logic                  wr_en;
    logic                  err_set;

    assign state_out = state;

    // Chip-select release overrides everything, dropping any byte in that cycle
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_ptr;
        auto_nxt  = auto_inc;
        wr_en     = 1'b0;
        err_set   = 1'b0;
        if (!transaction_valid_in) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD: begin
                    if (rx_valid_in) begin
                        addr_nxt  = rx_data_in[ADDR_WIDTH-1:0];
                        auto_nxt  = rx_data_in[CMD_AUTO_INC_BIT];
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (rx_valid_in) begin
                        wr_en = 1'b1;
                        if (auto_inc) begin
                            addr_nxt = addr_ptr + 1'b1;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (rx_valid_in) begin
                        err_set = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= IDLE;
            addr_ptr      <= '0;
            auto_inc      <= 1'b0;
            wr_strobe_out <= 1'b0;
            wr_addr_out   <= '0;
            cmd_error_out <= 1'b0;
        end else begin
            state         <= state_nxt;
            addr_ptr      <= addr_nxt;
            auto_inc      <= auto_nxt;
            wr_strobe_out <= wr_en;
            if (wr_en) begin
                wr_addr_out <= addr_ptr;
            end
            if (err_set) begin
                cmd_error_out <= 1'b1;
            end
        end
    end

    spi_reg_bank #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
        .clk       (clk_in),
        .reset     (reset_in),
        .wr_en     (wr_en),
        .wr_addr   (addr_ptr),
        .wr_data   (rx_data_in[DATA_WIDTH-1:0]),
        .txn_active(transaction_valid_in),
        .regs      (regs_out)
    );

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: transaction-level model plus directed literal checks.
// Covers both builds; the SHADOW_COMMIT_EN scenario runs only when that macro is defined.
module tb_spi_cmd_decoder;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         txn;
    logic [127:0] regs_out;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic         cmd_err;
    logic [1:0]   state;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;
    logic [3:0] strobe_log[$];

    always #5 clk = ~clk;

    spi_cmd_decoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk_in              (clk),
        .reset_in            (reset),
        .rx_data_in          (rx_data),
        .rx_valid_in         (rx_valid),
        .transaction_valid_in(txn),
        .regs_out            (regs_out),
        .wr_strobe_out       (wr_strobe),
        .wr_addr_out         (wr_addr),
        .cmd_error_out       (cmd_err),
        .state_out           (state)
    );

    // Transaction-level model: byte index within the current chip-select window
    logic [7:0] m_regs[16];
    logic [7:0] m_shadow[16];
    logic       m_dirty, m_strobe, m_err, m_in_txn, m_auto;
    logic [3:0] m_addr;
    int         m_idx, m_start, wa;

    always @(posedge clk) begin
        m_strobe = 1'b0;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = 8'h00;
                m_shadow[i] = 8'h00;
            end
            m_dirty = 0; m_err = 0; m_in_txn = 0; m_idx = 0; m_addr = 0;
            m_auto = 0; m_start = 0;
        end else if (!txn) begin
            m_in_txn = 0;
            m_idx = 0;
`ifdef SHADOW_COMMIT_EN
            if (m_dirty) begin
                for (int i = 0; i < 16; i++) m_regs[i] = m_shadow[i];
                m_dirty = 0;
            end
`endif
        end else if (!m_in_txn) begin
            m_in_txn = 1;
            m_idx = 0;
        end else if (rx_valid) begin
            if (m_idx == 0) begin
                m_start = int'(rx_data[3:0]);
                m_auto = rx_data[7];
            end else if (m_auto || m_idx == 1) begin
                wa = m_auto ? (m_start + m_idx - 1) % 16 : m_start;
`ifdef SHADOW_COMMIT_EN
                m_shadow[wa] = rx_data;
                m_dirty = 1;
`else
                m_regs[wa] = rx_data;
`endif
                m_strobe = 1'b1;
                m_addr = 4'(wa);
            end else begin
                m_err = 1'b1;
            end
            m_idx++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus a log of strobed addresses
    always @(negedge clk) begin
        logic [127:0] ef;
        if (cmp_en) begin
            for (int i = 0; i < 16; i++) ef[i*8 +: 8] = m_regs[i];
            chk("cyc_regs", regs_out, ef);
            chk("cyc_strobe", {127'd0, wr_strobe}, {127'd0, m_strobe});
            chk("cyc_addr", {124'd0, wr_addr}, {124'd0, m_addr});
            chk("cyc_err", {127'd0, cmd_err}, {127'd0, m_err});
            if (wr_strobe) strobe_log.push_back(wr_addr);
        end
    end

    task automatic cyc(input logic t, input logic v, input logic [7:0] d);
        @(negedge clk);
        txn = t; rx_valid = v; rx_data = d;
    endtask

    task automatic send_txn(input logic [7:0] b0, b1, b2, input int n, input int gap);
        logic [7:0] b[3];
        b[0] = b0; b[1] = b1; b[2] = b2;
        cyc(1, 0, 8'h00);
        cyc(1, 0, 8'h00);
        for (int i = 0; i < n; i++) begin
            cyc(1, 1, b[i]);
            repeat (gap) cyc(1, 0, 8'h00);
        end
        cyc(1, 0, 8'h00);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
    endtask

    initial begin
        reset = 1'b1; txn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_state", {126'd0, state}, 128'd0);
        chk("reset_regs", regs_out, 128'd0);
        chk("reset_err", {127'd0, cmd_err}, 128'd0);
        reset = 1'b0;

        // Auto-increment write of two registers
        strobe_log.delete();
        send_txn(8'h83, 8'h11, 8'h22, 3, 1);
        chk("t1_reg3", {120'd0, regs_out[31:24]}, 128'h11);
        chk("t1_reg4", {120'd0, regs_out[39:32]}, 128'h22);
        chk("t1_nstrobe", 128'(strobe_log.size()), 128'd2);
        if (strobe_log.size() == 2) begin
            chk("t1_addr0", {124'd0, strobe_log[0]}, 128'd3);
            chk("t1_addr1", {124'd0, strobe_log[1]}, 128'd4);
        end

        // Back-to-back bytes with address wraparound
        strobe_log.delete();
        send_txn(8'h8F, 8'hAA, 8'hBB, 3, 0);
        chk("t2_reg15", {120'd0, regs_out[127:120]}, 128'hAA);
        chk("t2_reg0", {120'd0, regs_out[7:0]}, 128'hBB);
        chk("t2_nstrobe", 128'(strobe_log.size()), 128'd2);

        // Non-auto-increment: second data byte dropped, sticky error
        strobe_log.delete();
        send_txn(8'h05, 8'h5A, 8'h77, 3, 1);
        chk("t3_reg5", {120'd0, regs_out[47:40]}, 128'h5A);
        chk("t3_err", {127'd0, cmd_err}, 128'd1);
        chk("t3_nstrobe", 128'(strobe_log.size()), 128'd1);

        // Byte arriving as chip-select drops is discarded
        strobe_log.delete();
        cyc(1, 0, 8'h00); cyc(1, 0, 8'h00);
        cyc(1, 1, 8'h84); cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h99); cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);
        chk("t4_reg4_kept", {120'd0, regs_out[39:32]}, 128'h22);
        chk("t4_nostrobe", 128'(strobe_log.size()), 128'd0);
        send_txn(8'h82, 8'h01, 8'h00, 2, 1);
        chk("t4_reg2", {120'd0, regs_out[23:16]}, 128'h01);
        chk("t4_err_sticky", {127'd0, cmd_err}, 128'd1);

        // Reset mid-transaction; next byte becomes the command byte
        cyc(1, 0, 8'h00); cyc(1, 0, 8'h00);
        cyc(1, 1, 8'h81); cyc(1, 0, 8'h00);
        @(negedge clk); reset = 1'b1; rx_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        strobe_log.delete();
        chk("t5_regs_zero", regs_out, 128'd0);
        chk("t5_state_idle", {126'd0, state}, 128'd0);
        chk("t5_err_clear", {127'd0, cmd_err}, 128'd0);
        cyc(1, 0, 8'h00); cyc(1, 0, 8'h00);
        cyc(1, 1, 8'h33); cyc(1, 0, 8'h00);
        cyc(1, 1, 8'h44); cyc(1, 0, 8'h00);
        cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);
        chk("t5_regs", regs_out, 128'h44 << 24);
        chk("t5_nstrobe", 128'(strobe_log.size()), 128'd1);
        if (strobe_log.size() == 1) chk("t5_addr", {124'd0, strobe_log[0]}, 128'd3);

`ifdef SHADOW_COMMIT_EN
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        cyc(1, 0, 8'h00); cyc(1, 0, 8'h00);
        cyc(1, 1, 8'h80); cyc(1, 1, 8'h01); cyc(1, 1, 8'h02);
        cyc(1, 0, 8'h00);
        chk("t6_hidden", regs_out, 128'd0);
        cyc(0, 0, 8'h00);
        chk("t6_pre_commit", regs_out, 128'd0);
        cyc(0, 0, 8'h00);
        chk("t6_commit", regs_out, 128'h0201);
`endif

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
